// File: rtl/mux_sel_sequencer.sv
// mux_sel_sequencer: accepts an 8-bit word over valid/ready, holds it on i,
// and steps the 8:1 mux select s through all positions to serialise it.
// Provides the selected bit, a bit-valid strobe and an end-of-frame pulse.
module mux_sel_sequencer #(
    parameter int DWELL     = 1,   // cycles per select value, 1..16
    parameter bit MSB_FIRST = 1'b0 // 0: s 0->7, 1: s 7->0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] load_data,
    input  logic       load_valid,
    output logic       load_ready,
    input  logic       hold,
    output logic [7:0] i,
    output logic [2:0] s,
    output logic       bit_out,
    output logic       bit_valid,
    output logic       frame_done
);

    localparam logic [3:0] DW_LAST = 4'(DWELL - 1);
    localparam logic [2:0] S_FIRST = MSB_FIRST ? 3'd7 : 3'd0;
    localparam logic [2:0] S_LAST  = MSB_FIRST ? 3'd0 : 3'd7;

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t     state, state_n;
    logic [3:0] dwell, dwell_n;
    logic [7:0] i_n;
    logic [2:0] s_n;
    logic       step, last, accept;

    // Next-state and handshake/strobe decode; outputs are forced low in reset
    always_comb begin
        state_n    = state;
        dwell_n    = dwell;
        i_n        = i;
        s_n        = s;
        step       = (state == SHIFT) && !hold && (dwell == DW_LAST);
        last       = step && (s == S_LAST);
        load_ready = !rst && ((state == IDLE) || last);
        bit_valid  = !rst && (state == SHIFT) && !hold;
        frame_done = !rst && last;
        accept     = load_valid && load_ready;

        if (accept) begin
            // Reload from IDLE or on the last cycle: no bubble between frames
            i_n     = load_data;
            s_n     = S_FIRST;
            dwell_n = 4'd0;
            state_n = SHIFT;
        end else if (state == SHIFT && !hold) begin
            if (dwell == DW_LAST) begin
                dwell_n = 4'd0;
                if (s == S_LAST)
                    state_n = IDLE;   // s and i keep their final values
                else
                    s_n = MSB_FIRST ? s - 3'd1 : s + 3'd1;
            end else begin
                dwell_n = dwell + 4'd1;
            end
        end
    end

    // State, word, select and dwell registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            dwell <= 4'd0;
            i     <= 8'h00;
            s     <= 3'd0;
        end else begin
            state <= state_n;
            dwell <= dwell_n;
            i     <= i_n;
            s     <= s_n;
        end
    end

    assign bit_out = i[s];

endmodule

// File: tb/tb_mux_sel_sequencer.sv
// Bench for mux_sel_sequencer: three parameterisations share one stimulus
// stream and are each checked against a frame-position reference model,
// plus a vector table and directed multi-cycle sequences.
module tb_mux_sel_sequencer;

    logic       clk = 1'b0;
    logic       rst, load_valid, hold;
    logic [7:0] load_data;

    logic [7:0] i_o   [3];
    logic [2:0] s_o   [3];
    logic       rdy_o [3], bit_o [3], vld_o [3], done_o [3];

    always #5 clk = ~clk;

    mux_sel_sequencer #(.DWELL(1), .MSB_FIRST(1'b0)) u0 (
        .clk(clk), .rst(rst), .load_data(load_data), .load_valid(load_valid),
        .load_ready(rdy_o[0]), .hold(hold), .i(i_o[0]), .s(s_o[0]),
        .bit_out(bit_o[0]), .bit_valid(vld_o[0]), .frame_done(done_o[0]));
    mux_sel_sequencer #(.DWELL(1), .MSB_FIRST(1'b1)) u1 (
        .clk(clk), .rst(rst), .load_data(load_data), .load_valid(load_valid),
        .load_ready(rdy_o[1]), .hold(hold), .i(i_o[1]), .s(s_o[1]),
        .bit_out(bit_o[1]), .bit_valid(vld_o[1]), .frame_done(done_o[1]));
    mux_sel_sequencer #(.DWELL(3), .MSB_FIRST(1'b0)) u2 (
        .clk(clk), .rst(rst), .load_data(load_data), .load_valid(load_valid),
        .load_ready(rdy_o[2]), .hold(hold), .i(i_o[2]), .s(s_o[2]),
        .bit_out(bit_o[2]), .bit_valid(vld_o[2]), .frame_done(done_o[2]));

    int vecs = 0;
    int miss = 0;

    // Reference model: a frame is 8*D counted (non-hold) cycles; position p
    // in that count determines s directly.
    int         md [3] = '{1, 1, 3};
    bit         mm [3] = '{1'b0, 1'b1, 1'b0};
    bit         busy [3];
    logic [7:0] word [3];
    int         pos  [3];
    int         sidle[3];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        vecs++;
        if (act !== exp) begin
            miss++;
            $display("FAIL %s t=%0t act=%h exp=%h", name, $time, act, exp);
        end
    endtask

    function automatic bit m_last(input int k);
        return busy[k] && !hold && pos[k] == 8 * md[k] - 1;
    endfunction

    function automatic int m_s(input int k);
        if (!busy[k]) return sidle[k];
        return mm[k] ? 7 - pos[k] / md[k] : pos[k] / md[k];
    endfunction

    task automatic model_check();
        for (int k = 0; k < 3; k++) begin
            int es;
            es = m_s(k);
            chk($sformatf("m%0d_i", k), i_o[k], word[k]);
            chk($sformatf("m%0d_s", k), 8'(s_o[k]), 8'(es));
            chk($sformatf("m%0d_bit", k), 8'(bit_o[k]), 8'(word[k][es]));
            chk($sformatf("m%0d_valid", k), 8'(vld_o[k]), 8'(!rst && busy[k] && !hold));
            chk($sformatf("m%0d_done", k), 8'(done_o[k]), 8'(!rst && m_last(k)));
            chk($sformatf("m%0d_ready", k), 8'(rdy_o[k]), 8'(!rst && (!busy[k] || m_last(k))));
        end
    endtask

    task automatic model_next();
        for (int k = 0; k < 3; k++) begin
            bit lastc, rdy;
            lastc = m_last(k);
            rdy   = !busy[k] || lastc;
            if (rst) begin
                busy[k] = 0; word[k] = 8'h00; pos[k] = 0; sidle[k] = 0;
            end else if (load_valid && rdy) begin
                busy[k] = 1; word[k] = load_data; pos[k] = 0;
            end else if (busy[k] && !hold) begin
                if (lastc) begin
                    busy[k] = 0; sidle[k] = mm[k] ? 0 : 7;
                end else begin
                    pos[k]++;
                end
            end
        end
    endtask

    task automatic drive(input logic r, input logic lv, input logic [7:0] d, input logic h);
        @(negedge clk);
        rst = r; load_valid = lv; load_data = d; hold = h;
        #1;
        model_check();
    endtask

    task automatic advance();
        model_next();
        @(posedge clk);
    endtask

    task automatic idle(input int n);
        for (int c = 0; c < n; c++) begin
            drive(0, 0, 8'h00, 0);
            advance();
        end
    endtask

    typedef struct {
        logic r, lv; logic [7:0] d; logic h;
        logic v, done, rdy;
        logic [2:0] s0; logic b0;
        logic [2:0] s1; logic b1;
    } vec_t;

    vec_t tbl[20];

    initial begin
        int cnt, ones_a, ones_b, done_c, bad;

        // Tests 1 and 2: A5 then 81 on the DWELL=1 instances (u0 LSB-first, u1 MSB-first)
        tbl[0] = '{1, 0, 8'h00, 0, 0, 0, 0, 3'd0, 0, 3'd0, 0};
        tbl[1] = '{0, 1, 8'hA5, 0, 0, 0, 1, 3'd0, 0, 3'd0, 0};
        tbl[2] = '{0, 0, 8'h00, 0, 1, 0, 0, 3'd0, 1, 3'd7, 1};
        tbl[3] = '{0, 0, 8'h00, 0, 1, 0, 0, 3'd1, 0, 3'd6, 0};
        tbl[4] = '{0, 0, 8'h00, 0, 1, 0, 0, 3'd2, 1, 3'd5, 1};
        tbl[5] = '{0, 0, 8'h00, 0, 1, 0, 0, 3'd3, 0, 3'd4, 0};
        tbl[6] = '{0, 0, 8'h00, 0, 1, 0, 0, 3'd4, 0, 3'd3, 0};
        tbl[7] = '{0, 0, 8'h00, 0, 1, 0, 0, 3'd5, 1, 3'd2, 1};
        tbl[8] = '{0, 0, 8'h00, 0, 1, 0, 0, 3'd6, 0, 3'd1, 0};
        tbl[9] = '{0, 0, 8'h00, 0, 1, 1, 1, 3'd7, 1, 3'd0, 1};
        tbl[10] = '{0, 1, 8'h81, 0, 0, 0, 1, 3'd7, 1, 3'd0, 1};
        tbl[11] = '{0, 0, 8'h00, 0, 1, 0, 0, 3'd0, 1, 3'd7, 1};
        tbl[12] = '{0, 0, 8'h00, 0, 1, 0, 0, 3'd1, 0, 3'd6, 0};
        tbl[13] = '{0, 0, 8'h00, 0, 1, 0, 0, 3'd2, 0, 3'd5, 0};
        tbl[14] = '{0, 0, 8'h00, 0, 1, 0, 0, 3'd3, 0, 3'd4, 0};
        tbl[15] = '{0, 0, 8'h00, 0, 1, 0, 0, 3'd4, 0, 3'd3, 0};
        tbl[16] = '{0, 0, 8'h00, 0, 1, 0, 0, 3'd5, 0, 3'd2, 0};
        tbl[17] = '{0, 0, 8'h00, 0, 1, 0, 0, 3'd6, 0, 3'd1, 0};
        tbl[18] = '{0, 0, 8'h00, 0, 1, 1, 1, 3'd7, 1, 3'd0, 1};
        tbl[19] = '{0, 0, 8'h00, 0, 0, 0, 1, 3'd7, 1, 3'd0, 1};

        rst = 1; load_valid = 0; load_data = 8'h00; hold = 0;
        repeat (2) @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            busy[k] = 0; word[k] = 8'h00; pos[k] = 0; sidle[k] = 0;
        end

        for (int n = 0; n < 20; n++) begin
            drive(tbl[n].r, tbl[n].lv, tbl[n].d, tbl[n].h);
            chk($sformatf("tbl%0d_valid", n), 8'(vld_o[0]), 8'(tbl[n].v));
            chk($sformatf("tbl%0d_done", n), 8'(done_o[0]), 8'(tbl[n].done));
            chk($sformatf("tbl%0d_ready", n), 8'(rdy_o[0]), 8'(tbl[n].rdy));
            chk($sformatf("tbl%0d_s0", n), 8'(s_o[0]), 8'(tbl[n].s0));
            chk($sformatf("tbl%0d_b0", n), 8'(bit_o[0]), 8'(tbl[n].b0));
            chk($sformatf("tbl%0d_s1", n), 8'(s_o[1]), 8'(tbl[n].s1));
            chk($sformatf("tbl%0d_b1", n), 8'(bit_o[1]), 8'(tbl[n].b1));
            chk($sformatf("tbl%0d_done1", n), 8'(done_o[1]), 8'(tbl[n].done));
            advance();
        end

        // Test 3: DWELL=3 with 0F -> 24-cycle frame, 12 ones then 12 zeros
        idle(30);
        drive(0, 1, 8'h0F, 0); advance();
        ones_a = 0; ones_b = 0; done_c = 0;
        for (int c = 1; c <= 24; c++) begin
            drive(0, 0, 8'h00, 0);
            if (vld_o[2] && bit_o[2]) begin
                if (c <= 12) ones_a++; else ones_b++;
            end
            if (done_o[2]) done_c = c;
            advance();
        end
        chk("t3_first12_ones", 8'(ones_a), 8'd12);
        chk("t3_last12_ones", 8'(ones_b), 8'd0);
        chk("t3_done_cycle", 8'(done_c), 8'd24);

        // Test 4: FF with hold on bit cycles 3-5 -> s frozen at 2, done on cycle 11
        idle(30);
        drive(0, 1, 8'hFF, 0); advance();
        done_c = 0;
        for (int c = 1; c <= 14; c++) begin
            drive(0, 0, 8'h00, (c >= 3 && c <= 5));
            if (c >= 3 && c <= 5) begin
                chk($sformatf("t4_hold_s_c%0d", c), 8'(s_o[0]), 8'd2);
                chk($sformatf("t4_hold_valid_c%0d", c), 8'(vld_o[0]), 8'd0);
            end
            if (done_o[0] && done_c == 0) done_c = c;
            advance();
        end
        chk("t4_done_cycle", 8'(done_c), 8'd11);

        // Test 5: back-to-back AA then 55 with load_valid held high
        idle(30);
        drive(0, 1, 8'hAA, 0); advance();
        cnt = 0; bad = 0;
        for (int c = 1; c <= 16; c++) begin
            drive(0, (c <= 8), 8'h55, 0);
            if (vld_o[0]) cnt++;
            if (rdy_o[0] != done_o[0]) bad++;
            if (c == 1) chk("t5_first_bit", 8'(bit_o[0]), 8'd0);
            if (c == 9) chk("t5_second_frame_i", i_o[0], 8'h55);
            advance();
        end
        chk("t5_valid_run", 8'(cnt), 8'd16);
        chk("t5_ready_only_with_done", 8'(bad), 8'd0);

        // Test 6: reset on bit cycle 4 abandons the frame
        idle(30);
        drive(0, 1, 8'hFF, 0); advance();
        for (int c = 1; c <= 3; c++) begin
            drive(0, 0, 8'h00, 0); advance();
        end
        drive(1, 0, 8'h00, 0);
        chk("t6_rst_done", 8'(done_o[0]), 8'd0);
        chk("t6_rst_ready", 8'(rdy_o[0]), 8'd0);
        advance();
        drive(0, 0, 8'h00, 0);
        chk("t6_i_cleared", i_o[0], 8'h00);
        chk("t6_s_cleared", 8'(s_o[0]), 8'd0);
        chk("t6_valid_low", 8'(vld_o[0]), 8'd0);
        chk("t6_ready_high", 8'(rdy_o[0]), 8'd1);
        advance();

        // Random traffic against the model; upstream holds its word until accepted
        begin
            logic [7:0] pend;
            bit         have;
            have = 0; pend = 8'h00;
            for (int c = 0; c < 3000; c++) begin
                logic r, h;
                if (!have && $urandom_range(0, 2) != 0) begin
                    have = 1; pend = 8'($urandom);
                end
                r = ($urandom_range(0, 199) == 0);
                h = ($urandom_range(0, 3) == 0);
                drive(r, have, pend, h);
                // Stimulus is released once any instance takes it, so some
                // words go only to instances that were ready; the model follows each.
                if (have && !r && (rdy_o[0] || rdy_o[1] || rdy_o[2])) have = 0;
                advance();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

endmodule
